// File: rtl/imem_port_arbiter.sv
// Two-port (fetch/debug) arbiter for the single read port of the boot instruction ROM.
// Optional build macro IMEM_ARB_RR_EN selects round-robin instead of fetch-first priority.
module imem_port_arbiter #(
    parameter int                 A_WIDTH   = 32,
    parameter logic [A_WIDTH-1:0] ROM_BASE  = 32'hBFC00000,
    parameter int                 ROM_BYTES = 4096,
    parameter int                 MEM_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               f_req,
    input  logic [A_WIDTH-1:0] f_addr,
    output logic               f_gnt,
    output logic               f_rvalid,
    output logic [31:0]        f_rdata,
    output logic               f_err,
    input  logic               d_req,
    input  logic [A_WIDTH-1:0] d_addr,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [31:0]        d_rdata,
    output logic               d_err,
    output logic               mem_en,
    output logic [A_WIDTH-1:0] mem_addr,
    input  logic [31:0]        mem_rdata,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Last byte address inside the ROM, one bit wider so the end check cannot wrap.
    localparam logic [A_WIDTH:0] ROM_LAST = {1'b0, ROM_BASE} + (A_WIDTH+1)'(ROM_BYTES - 1);

    state_t             state_reg;
    logic               owner_reg;
    logic [2:0]         cnt_reg;
    logic               mem_en_reg;
    logic [A_WIDTH-1:0] mem_addr_reg;
    logic               f_rvalid_reg, d_rvalid_reg;
    logic               f_err_reg, d_err_reg;
    logic [31:0]        f_rdata_reg, d_rdata_reg;

    logic               any_req;
    logic               pick_d;
    logic               grant_ok;
    logic [A_WIDTH-1:0] req_addr;
    logic [A_WIDTH:0]   req_last;
    logic               addr_bad;

    assign any_req = f_req | d_req;

`ifdef IMEM_ARB_RR_EN
    logic last_grant_reg;  // 1: debug was granted last
    assign pick_d = d_req && (!f_req || !last_grant_reg);
`else
    assign pick_d = d_req && !f_req;
`endif

    assign grant_ok = (state_reg == IDLE) && !rst && any_req;
    assign f_gnt    = grant_ok && !pick_d;
    assign d_gnt    = grant_ok && pick_d;

    assign req_addr = pick_d ? d_addr : f_addr;
    assign req_last = {1'b0, req_addr} + (A_WIDTH+1)'(3);
    assign addr_bad = (req_addr[1:0] != 2'b00) || (req_addr < ROM_BASE) || (req_last > ROM_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            cnt_reg      <= 3'd0;
            mem_en_reg   <= 1'b0;
            mem_addr_reg <= '0;
            f_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            f_err_reg    <= 1'b0;
            d_err_reg    <= 1'b0;
            f_rdata_reg  <= 32'd0;
            d_rdata_reg  <= 32'd0;
`ifdef IMEM_ARB_RR_EN
            last_grant_reg <= 1'b1;
`endif
        end else begin
            f_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
            f_err_reg    <= 1'b0;
            d_err_reg    <= 1'b0;
            mem_en_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        owner_reg <= pick_d;
`ifdef IMEM_ARB_RR_EN
                        last_grant_reg <= pick_d;
`endif
                        if (addr_bad) begin
                            // Rejected accesses never touch the ROM.
                            state_reg <= RESP;
                            if (pick_d) begin
                                d_rvalid_reg <= 1'b1;
                                d_err_reg    <= 1'b1;
                                d_rdata_reg  <= 32'd0;
                            end else begin
                                f_rvalid_reg <= 1'b1;
                                f_err_reg    <= 1'b1;
                                f_rdata_reg  <= 32'd0;
                            end
                        end else begin
                            state_reg    <= ISSUE;
                            mem_en_reg   <= 1'b1;
                            mem_addr_reg <= req_addr;
                        end
                    end
                end
                ISSUE: begin
                    cnt_reg   <= 3'(MEM_LAT);
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (cnt_reg == 3'd1) begin
                        state_reg <= RESP;
                        if (owner_reg) begin
                            d_rvalid_reg <= 1'b1;
                            d_rdata_reg  <= mem_rdata;
                        end else begin
                            f_rvalid_reg <= 1'b1;
                            f_rdata_reg  <= mem_rdata;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_en   = mem_en_reg;
    assign mem_addr = mem_addr_reg;
    assign f_rvalid = f_rvalid_reg;
    assign d_rvalid = d_rvalid_reg;
    assign f_err    = f_err_reg;
    assign d_err    = d_err_reg;
    assign f_rdata  = f_rdata_reg;
    assign d_rdata  = d_rdata_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: one instance with ROM latency 1, one with latency 3,
// each driven by directed and random requests against a spec-level model.
module tb_imem_port_arbiter;

    localparam logic [31:0] BASE = 32'hBFC00000;
`ifdef IMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit          port;   // 1 = debug
        bit          err;
        logic [31:0] addr;
        logic [31:0] data;
        int          gcyc;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rom [4096];

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h13; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h00;
    end

    task automatic check(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL inst%0d %s: got 0x%08h expected 0x%08h", inst, name, act, exp_v);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        longint o;
        o = longint'(a) - longint'(BASE);
        if (o < 0 || o > 4092) return 32'hDEADBEEF;
        return {rom[int'(o)+3], rom[int'(o)+2], rom[int'(o)+1], rom[int'(o)]};
    endfunction

    // Address rule evaluated in 64-bit arithmetic, so nothing can wrap.
    function automatic bit ref_err(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la % 4 != 0) || (la < longint'(BASE)) || (la + 3 > longint'(BASE) + 4095);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] edges [5];
        edges[0] = 32'hBFC00FFC; edges[1] = 32'hBFC01000; edges[2] = 32'hBFBFFFFC;
        edges[3] = 32'hFFFFFFFC; edges[4] = 32'hBFC00FFD;
        case ($urandom_range(0, 5))
            0, 1, 2: return BASE + 32'($urandom_range(0, 1023)) * 4;
            3:       return BASE + 32'($urandom_range(0, 4095));
            4:       return $urandom;
            default: return edges[$urandom_range(0, 4)];
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;

        logic        rst, f_req, d_req, f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err, mem_en, busy;
        logic [31:0] f_addr, d_addr, f_rdata, d_rdata, mem_addr, mem_rdata;

        imem_port_arbiter #(.MEM_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
            .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
            .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
        );

        int          cyc = 0;
        exp_t        sbq[$];
        int          free_cyc = 0;
        int          memen_cnt = 0;
        logic [31:0] f_last = 32'd0, d_last = 32'd0;
        bit          last_d = 1'b1;
        bit          done = 1'b0;
        int          pend = 0;
        logic [31:0] pend_addr = 32'd0;

        always @(posedge clk) cyc <= cyc + 1;

        // ROM: word valid exactly LAT cycles after the strobe, garbage otherwise.
        always @(posedge clk) begin
            mem_rdata <= $urandom;
            if (rst) begin
                pend <= 0;
            end else if (mem_en) begin
                if (LAT == 1) mem_rdata <= rom_word(mem_addr);
                else begin
                    pend      <= LAT - 1;
                    pend_addr <= mem_addr;
                end
            end else if (pend == 1) begin
                mem_rdata <= rom_word(pend_addr);
                pend      <= 0;
            end else if (pend > 1) begin
                pend <= pend - 1;
            end
        end

        always @(negedge clk) begin : mon
            exp_t e;
            if (!rst) begin
                check(gi, "busy", 32'(busy), 32'(sbq.size() != 0 && cyc > sbq[0].gcyc));
                if (mem_en) begin
                    memen_cnt++;
                    check(gi, "mem_en_slot", 32'(sbq.size() != 0 && !sbq[0].err && cyc == sbq[0].gcyc + 1), 32'd1);
                    if (sbq.size() != 0) check(gi, "mem_addr", mem_addr, sbq[0].addr);
                end
                if (f_rvalid || d_rvalid) begin
                    check(gi, "rvalid_onehot", 32'(f_rvalid && d_rvalid), 32'd0);
                    check(gi, "rvalid_outstanding", 32'(sbq.size()), 32'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        $display("txn inst%0d port=%s addr=%08h err=%0d data=%08h lat=%0d",
                                 gi, e.port ? "D" : "F", e.addr, e.err, e.data, cyc - e.gcyc);
                        check(gi, "rvalid_port", 32'(d_rvalid), 32'(e.port));
                        check(gi, "err", 32'(e.port ? d_err : f_err), 32'(e.err));
                        check(gi, "rdata", e.port ? d_rdata : f_rdata, e.data);
                        check(gi, "latency", 32'(cyc - e.gcyc), e.err ? 32'd1 : 32'(LAT + 2));
                        check(gi, "mem_en_count", 32'(memen_cnt), e.err ? 32'd0 : 32'd1);
                        if (e.port) d_last = e.data;
                        else        f_last = e.data;
                    end
                    free_cyc  = cyc + 1;
                    memen_cnt = 0;
                end
                check(gi, "f_err_idle", 32'(f_err && !f_rvalid), 32'd0);
                check(gi, "d_err_idle", 32'(d_err && !d_rvalid), 32'd0);
                check(gi, "f_rdata_hold", f_rdata, f_last);
                check(gi, "d_rdata_hold", d_rdata, d_last);
            end
        end

        task automatic clear_model();
            sbq.delete();
            free_cyc  = 0;
            memen_cnt = 0;
            f_last    = 32'd0;
            d_last    = 32'd0;
            last_d    = 1'b1;
        endtask

        task automatic check_all_zero(input string tag);
            logic [31:0] ctl;
            ctl = {22'd0, f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err, mem_en, busy, 2'b00};
            check(gi, {tag, "_ctl"}, ctl, 32'd0);
            check(gi, {tag, "_f_rdata"}, f_rdata, 32'd0);
            check(gi, {tag, "_d_rdata"}, d_rdata, 32'd0);
            check(gi, {tag, "_mem_addr"}, mem_addr, 32'd0);
        endtask

        // Present requests; the granted port keeps requesting until 'hold' grants have been made.
        task automatic run(input bit rf, input bit rd, input logic [31:0] fa, input logic [31:0] da, input int hold);
            bit   pf, pd, ed, gf, gd;
            int   ngnt, budget;
            exp_t e;
            @(posedge clk); #1;
            f_req = rf; f_addr = fa; d_req = rd; d_addr = da;
            pf = rf; pd = rd; ngnt = 0; budget = 0;
            while ((pf || pd) && budget < 300) begin
                @(negedge clk);
                budget++;
                gf = f_gnt; gd = d_gnt;
                if (sbq.size() == 0 && cyc >= free_cyc) check(gi, "gnt_present", 32'(gf || gd), 32'd1);
                if (gf || gd) begin
                    ed = pd && (!pf || (RR && !last_d));
                    check(gi, "gnt_onehot", 32'(gf && gd), 32'd0);
                    check(gi, "gnt_winner_is_d", 32'(gd), 32'(ed));
                    check(gi, "gnt_while_busy", 32'(sbq.size()), 32'd0);
                    e.port = ed;
                    e.addr = ed ? da : fa;
                    e.err  = ref_err(e.addr);
                    e.data = e.err ? 32'd0 : rom_word(e.addr);
                    e.gcyc = cyc;
                    sbq.push_back(e);
                    last_d = ed;
                    ngnt++;
                    @(posedge clk); #1;
                    if (ngnt >= hold) begin
                        if (gd) begin d_req = 1'b0; pd = 1'b0; end
                        else    begin f_req = 1'b0; pf = 1'b0; end
                    end
                end
            end
            if (pf || pd) begin
                checks++; errors++;
                $display("FAIL inst%0d gnt_timeout: got no grant expected grant within 300 cycles", gi);
                f_req = 1'b0; d_req = 1'b0;
            end
        endtask

        task automatic wait_idle();
            int b;
            b = 0;
            while ((sbq.size() != 0 || cyc < free_cyc) && b < 100) begin
                @(negedge clk);
                b++;
            end
            if (b >= 100) begin
                checks++; errors++;
                $display("FAIL inst%0d resp_timeout: got no rvalid expected rvalid within 100 cycles", gi);
            end
        endtask

        initial begin
            rst = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = 32'd0; d_addr = 32'd0;
            repeat (2) @(negedge clk);
            check_all_zero("reset");
            clear_model();
            rst = 1'b0;

            run(1'b1, 1'b0, BASE, 32'd0, 0);
            wait_idle();
            check(gi, "first_word", f_rdata, 32'h00000013);

            run(1'b0, 1'b1, 32'd0, BASE + 32'd2, 0);
            wait_idle();
            check(gi, "misaligned_d_err_data", d_rdata, 32'd0);

            run(1'b0, 1'b1, 32'd0, 32'hBFC00FFC, 0); wait_idle();
            run(1'b0, 1'b1, 32'd0, 32'hBFC01000, 0); wait_idle();
            run(1'b0, 1'b1, 32'd0, 32'hBFBFFFFC, 0); wait_idle();
            run(1'b0, 1'b1, 32'd0, 32'hFFFFFFFC, 0); wait_idle();

            run(1'b1, 1'b1, BASE + 32'd4, BASE + 32'd16, 4);
            wait_idle();

            // Debug request raised while a fetch access is in flight.
            run(1'b1, 1'b0, BASE + 32'd8, 32'd0, 0);
            run(1'b0, 1'b1, 32'd0, BASE + 32'd20, 0);
            wait_idle();

            // Asynchronous reset in the middle of WAIT.
            run(1'b1, 1'b0, BASE + 32'd12, 32'd0, 0);
            @(posedge clk); #3;
            rst = 1'b1;
            #1;
            check_all_zero("async_reset");
            clear_model();
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (LAT + 4) @(negedge clk);
            run(1'b1, 1'b0, BASE + 32'd24, 32'd0, 0);
            wait_idle();

            for (int n = 0; n < 40; n++) begin
                bit rf, rd;
                rf = 1'($urandom_range(0, 1));
                rd = rf ? 1'($urandom_range(0, 1)) : 1'b1;
                run(rf, rd, rand_addr(), rand_addr(), $urandom_range(0, 2));
                if ($urandom_range(0, 1) == 1) wait_idle();
            end
            wait_idle();
            done = 1'b1;
        end
    end

    initial begin
        int i;
        i = 0;
        while (!(g_dut[0].done && g_dut[1].done) && i < 60000) begin
            @(posedge clk);
            i++;
        end
        if (!(g_dut[0].done && g_dut[1].done)) begin
            checks++; errors++;
            $display("FAIL run_timeout: got unfinished sequence expected completion within 60000 cycles");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
Arbitrates the single read port of the byte-addressed instruction ROM (base 0xBFC00000) between two requesters: the pipeline fetch unit (port F) and the debug/self-test reader (port D). Validates each address, sequences one ROM access at a time against a fixed read latency, and returns the 32-bit little-endian word, or an error, to the granted requester. Sits between the fetch stage / debug unit and the instruction memory.

Parameters:
A_WIDTH, 32, address width
ROM_BASE, 32'hBFC00000, lowest valid byte address
ROM_BYTES, 4096, ROM size in bytes; valid range is ROM_BASE..ROM_BASE+ROM_BYTES-1
MEM_LAT, 1, cycles from mem_en to valid mem_rdata (1..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
f_req  in  1  fetch request; held with f_addr until f_gnt
f_addr  in  A_WIDTH  fetch byte address
f_gnt  out  1  one-cycle grant pulse to fetch
f_rvalid  out  1  one-cycle response pulse to fetch
f_rdata  out  32  fetch read data
f_err  out  1  error flag, valid with f_rvalid
d_req, d_addr, d_gnt, d_rvalid, d_rdata, d_err  same as the f_* ports, for the debug port
mem_en  out  1  ROM read strobe
mem_addr  out  A_WIDTH  ROM byte address
mem_rdata  in  32  ROM word {A+3,A+2,A+1,A}
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Reset forces state IDLE. All outputs go to 0: f_gnt, d_gnt, f_rvalid, d_rvalid, f_rdata, d_rdata, f_err, d_err, mem_en, mem_addr and busy. Reset mid-transaction discards the in-flight access; no rvalid is ever issued for it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, cycle T, at least one req high:
  - grant is combinational; exactly one of f_gnt/d_gnt is high.
  - Block latches the granted address and requester ID.
  - Priority: fixed, fetch over debug (see Optional Feature).
- Address check in cycle T: error if addr[1:0] != 0, or addr < ROM_BASE, or addr+3 > ROM_BASE+ROM_BYTES-1. Compute addr+3 at A_WIDTH+1 bits so it cannot wrap.
  - Error: go to RESP; mem_en is never asserted.
  - Valid: go to ISSUE.
- ISSUE (T+1): mem_en=1 and mem_addr=latched address, for exactly one cycle. Load the latency counter with MEM_LAT. Go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle mem_rdata is valid (T+1+MEM_LAT), register it into the granted port's rdata. Go to RESP.
- RESP:
  - Granted port's rvalid=1 for one cycle; rdata holds the registered word.
  - On error, err=1 and rdata=0.
  - Return to IDLE next cycle.
- Latency, gnt to rvalid: MEM_LAT+2 cycles for a valid access; 1 cycle for an error.
- The ungranted port's gnt, rvalid and err stay 0. Each port's rdata holds its last value until that port's next response.
- One outstanding transaction only. Requests are ignored (no gnt) outside IDLE; the requester keeps req and addr held.
- Simultaneous f_req and d_req: resolved by the priority rule. The loser stays pending and is granted in the first IDLE cycle in which it wins.
- req dropped before gnt: legal; nothing is issued.
- mem_addr holds its last value when mem_en=0.

Optional Feature:
IMEM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_grant register (reset to D, so fetch wins first) gives priority to the port not granted last. It updates only on a grant; a single requester is always granted.
- Undefined: fixed priority, fetch over debug; no last_grant register exists.

Test Plan:
- Reset, then f_req with f_addr=0xBFC00000, MEM_LAT=1, ROM bytes 13,00,00,00 -> f_gnt in T; mem_en and mem_addr=0xBFC00000 at T+1; f_rvalid at T+3 with f_rdata=0x00000013 and f_err=0.
- d_req with d_addr=0xBFC00002 -> d_gnt, mem_en never asserted, d_rvalid with d_err=1 and d_rdata=0 in the next cycle.
- d_addr=0xBFC00FFC gives a valid read. d_addr=0xBFC01000 and d_addr=0xBFBFFFFC each give an error. d_addr=0xFFFFFFFC gives an error with no wrap.
- f_req and d_req held together for 4 transactions:
  - Without the macro, all 4 grants go to F while D stays pending.
  - With IMEM_ARB_RR_EN, grants alternate F, D, F, D.
- MEM_LAT=3, f_req -> f_rvalid exactly 5 cycles after f_gnt; busy high from T+1 through the rvalid cycle. A d_req raised during the transaction is not granted until IDLE.
- rst asserted asynchronously mid-WAIT -> all outputs 0 immediately; no rvalid for the aborted access. A new f_req after release completes normally.
